memoria32_arbiter: RTL and testbench

//  Arbitrates the 2048x32 dual-port program memory between the CPU fetch unit (read-only) and the debug

---
 rtl/memoria32_arbiter.sv | 207 ++++++++++++++++++++
 tb/tb_memoria32_arbiter.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memoria32_arbiter.sv
// Program-memory arbiter: serialises CPU fetch reads and debug reads/writes onto the
// dual-port memory pins, with a bounded debug-priority streak so fetch cannot starve.
module memoria32_arbiter #(
    parameter int ADDR_W         = 11,
    parameter int DATA_W         = 32,
    parameter int DBG_MAX_STREAK = 4
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              cpu_halt,
    input  logic              f_req,
    input  logic [ADDR_W-1:0] f_addr,
    output logic              f_gnt,
    output logic              f_rvalid,
    output logic [DATA_W-1:0] f_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic              d_pair,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata0,
    input  logic [DATA_W-1:0] d_wdata1,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] mem_addr1,
    output logic [ADDR_W-1:0] mem_addr2,
    output logic [DATA_W-1:0] mem_wdata1,
    output logic [DATA_W-1:0] mem_wdata2,
    output logic              mem_web1,
    output logic              mem_web2,
    output logic              mem_halt,
    input  logic [DATA_W-1:0] mem_rdata
);

    localparam int STREAK_W = $clog2(DBG_MAX_STREAK + 1);
    localparam logic [STREAK_W-1:0] STREAK_MAX  = STREAK_W'(DBG_MAX_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_ONE  = STREAK_W'(1);
    localparam logic [STREAK_W-1:0] STREAK_ZERO = STREAK_W'(0);
    localparam logic [ADDR_W-1:0]   ADDR_ONE    = ADDR_W'(1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    state_t              state_r, state_s;
    logic [STREAK_W-1:0] streak_r, streak_s;
    logic                op_read_r, op_read_s;
    logic                rd_fetch_r, rd_fetch_s;
    logic                fetch_elig_s, force_fetch_s;

    logic                f_gnt_r, f_gnt_s, d_gnt_r, d_gnt_s;
    logic                f_rvalid_r, f_rvalid_s, d_rvalid_r, d_rvalid_s;
    logic                halt_r, halt_s, web1_r, web1_s, web2_r, web2_s;
    logic [ADDR_W-1:0]   addr1_r, addr1_s, addr2_r, addr2_s;
    logic [DATA_W-1:0]   wdata1_r, wdata1_s, wdata2_r, wdata2_s;
    logic [DATA_W-1:0]   f_rdata_r, f_rdata_s, d_rdata_r, d_rdata_s;

    assign fetch_elig_s  = f_req & ~cpu_halt;
    assign force_fetch_s = fetch_elig_s & (streak_r == STREAK_MAX);

    // Next-state, streak and next-output decode; every output register is loaded from here.
    always_comb begin
        state_s    = state_r;
        streak_s   = streak_r;
        op_read_s  = op_read_r;
        rd_fetch_s = rd_fetch_r;
        f_gnt_s    = 1'b0;
        d_gnt_s    = 1'b0;
        f_rvalid_s = 1'b0;
        d_rvalid_s = 1'b0;
        halt_s     = 1'b1;
        web1_s     = 1'b1;
        web2_s     = 1'b1;
        addr1_s    = addr1_r;
        addr2_s    = addr2_r;
        wdata1_s   = wdata1_r;
        wdata2_s   = wdata2_r;
        f_rdata_s  = f_rdata_r;
        d_rdata_s  = d_rdata_r;
        case (state_r)
            ST_IDLE: begin
                if (d_req && !force_fetch_s) begin
                    state_s    = ST_ACCESS;
                    d_gnt_s    = 1'b1;
                    halt_s     = 1'b0;
                    addr1_s    = d_addr;
                    rd_fetch_s = 1'b0;
                    op_read_s  = ~d_we;
                    if (d_we) begin
                        web1_s   = 1'b0;
                        wdata1_s = d_wdata0;
                        if (d_pair) begin
                            web2_s   = 1'b0;
                            addr2_s  = d_addr + ADDR_ONE;
                            wdata2_s = d_wdata1;
                        end else begin
                            web2_s = 1'b1;
                        end
                    end else begin
                        web1_s = 1'b1;
                    end
                    // Only debug wins that actually delay a waiting fetch count toward the limit.
                    if (fetch_elig_s) begin
                        streak_s = (streak_r == STREAK_MAX) ? streak_r : streak_r + STREAK_ONE;
                    end else begin
                        streak_s = STREAK_ZERO;
                    end
                end else if (fetch_elig_s) begin
                    state_s    = ST_ACCESS;
                    f_gnt_s    = 1'b1;
                    halt_s     = 1'b0;
                    addr1_s    = f_addr;
                    rd_fetch_s = 1'b1;
                    op_read_s  = 1'b1;
                    streak_s   = STREAK_ZERO;
                end else begin
                    streak_s = STREAK_ZERO;
                end
            end
            ST_ACCESS: begin
                if (op_read_r) begin
                    state_s = ST_RESP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RESP: begin
                state_s = ST_IDLE;
                if (rd_fetch_r) begin
                    f_rvalid_s = 1'b1;
                    f_rdata_s  = mem_rdata;
                end else begin
                    d_rvalid_s = 1'b1;
                    d_rdata_s  = mem_rdata;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // FSM and arbitration bookkeeping registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r    <= ST_IDLE;
            streak_r   <= STREAK_ZERO;
            op_read_r  <= 1'b0;
            rd_fetch_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            streak_r   <= streak_s;
            op_read_r  <= op_read_s;
            rd_fetch_r <= rd_fetch_s;
        end
    end

    // Registered memory pins and requester responses.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            f_gnt_r    <= 1'b0;
            d_gnt_r    <= 1'b0;
            f_rvalid_r <= 1'b0;
            d_rvalid_r <= 1'b0;
            halt_r     <= 1'b1;
            web1_r     <= 1'b1;
            web2_r     <= 1'b1;
            addr1_r    <= {ADDR_W{1'b0}};
            addr2_r    <= {ADDR_W{1'b0}};
            wdata1_r   <= {DATA_W{1'b0}};
            wdata2_r   <= {DATA_W{1'b0}};
            f_rdata_r  <= {DATA_W{1'b0}};
            d_rdata_r  <= {DATA_W{1'b0}};
        end else begin
            f_gnt_r    <= f_gnt_s;
            d_gnt_r    <= d_gnt_s;
            f_rvalid_r <= f_rvalid_s;
            d_rvalid_r <= d_rvalid_s;
            halt_r     <= halt_s;
            web1_r     <= web1_s;
            web2_r     <= web2_s;
            addr1_r    <= addr1_s;
            addr2_r    <= addr2_s;
            wdata1_r   <= wdata1_s;
            wdata2_r   <= wdata2_s;
            f_rdata_r  <= f_rdata_s;
            d_rdata_r  <= d_rdata_s;
        end
    end

    assign f_gnt      = f_gnt_r;
    assign d_gnt      = d_gnt_r;
    assign f_rvalid   = f_rvalid_r;
    assign d_rvalid   = d_rvalid_r;
    assign f_rdata    = f_rdata_r;
    assign d_rdata    = d_rdata_r;
    assign mem_halt   = halt_r;
    assign mem_web1   = web1_r;
    assign mem_web2   = web2_r;
    assign mem_addr1  = addr1_r;
    assign mem_addr2  = addr2_r;
    assign mem_wdata1 = wdata1_r;
    assign mem_wdata2 = wdata2_r;

endmodule

// File: tb/tb_memoria32_arbiter.sv
// Bench for memoria32_arbiter: directed scenarios plus randomized traffic checked against a
// transaction-timeline model of the arbiter and a behavioural synchronous memory.
module tb_memoria32_arbiter;

    localparam int AW = 11;
    localparam int DW = 32;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b1;
    logic          cpu_halt = 1'b0;
    logic          f_req = 1'b0;
    logic [AW-1:0] f_addr = '0;
    logic          f_gnt, f_rvalid;
    logic [DW-1:0] f_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_pair = 1'b0;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata0 = '0, d_wdata1 = '0;
    logic          d_gnt, d_rvalid;
    logic [DW-1:0] d_rdata;
    logic [AW-1:0] mem_addr1, mem_addr2;
    logic [DW-1:0] mem_wdata1, mem_wdata2;
    logic          mem_web1, mem_web2, mem_halt;
    logic [DW-1:0] mem_rdata = '0;

    logic [DW-1:0] mem [0:2047];
    int n_checks = 0;
    int n_fail = 0;

    memoria32_arbiter #(.ADDR_W(AW), .DATA_W(DW), .DBG_MAX_STREAK(4)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .cpu_halt(cpu_halt),
        .f_req(f_req), .f_addr(f_addr), .f_gnt(f_gnt), .f_rvalid(f_rvalid), .f_rdata(f_rdata),
        .d_req(d_req), .d_we(d_we), .d_pair(d_pair), .d_addr(d_addr),
        .d_wdata0(d_wdata0), .d_wdata1(d_wdata1),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
        .mem_addr1(mem_addr1), .mem_addr2(mem_addr2), .mem_wdata1(mem_wdata1),
        .mem_wdata2(mem_wdata2), .mem_web1(mem_web1), .mem_web2(mem_web2),
        .mem_halt(mem_halt), .mem_rdata(mem_rdata)
    );

    always #5 Clk = ~Clk;

    // Synchronous dual-port memory: port-1 read data appears the cycle after the access.
    always @(posedge Clk) begin
        if (!mem_halt) begin
            if (!mem_web1) mem[mem_addr1] <= mem_wdata1;
            if (!mem_web2) mem[mem_addr2] <= mem_wdata2;
            mem_rdata <= mem[mem_addr1];
        end
    end

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic clear_inputs;
        cpu_halt = 1'b0; f_req = 1'b0; f_addr = '0;
        d_req = 1'b0; d_we = 1'b0; d_pair = 1'b0; d_addr = '0; d_wdata0 = '0; d_wdata1 = '0;
    endtask

    task automatic do_reset;
        Reset_n = 1'b0;
        clear_inputs();
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_reset;
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({f_gnt, d_gnt, f_rvalid, d_rvalid, mem_halt, mem_web1, mem_web2} !== 7'b0000111) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b want 0000111", {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_halt, mem_web1, mem_web2});
        end
        n_checks++;
        if ({mem_addr1, mem_addr2, mem_wdata1, mem_wdata2, f_rdata, d_rdata} !== '0) begin
            n_fail++;
            $display("FAIL reset_data: addr1=%h addr2=%h wd1=%h wd2=%h frd=%h drd=%h want all 0",
                     mem_addr1, mem_addr2, mem_wdata1, mem_wdata2, f_rdata, d_rdata);
        end
        tick();
        Reset_n = 1'b1;
    endtask

    task automatic test_fetch_read;
        mem[11'h010] = 32'hDEADBEEF;
        f_req = 1'b1; f_addr = 11'h010;
        tick();
        n_checks++;
        if ({f_gnt, d_gnt, mem_halt, mem_web1, mem_web2, mem_addr1} !== {5'b10011, 11'h010}) begin
            n_fail++;
            $display("FAIL fetch_grant: gnt=%b dgnt=%b halt=%b web=%b%b addr1=%h want 1 0 0 11 010",
                     f_gnt, d_gnt, mem_halt, mem_web1, mem_web2, mem_addr1);
        end
        f_req = 1'b0;
        tick();
        n_checks++;
        if ({f_gnt, f_rvalid, mem_halt} !== 3'b001) begin
            n_fail++;
            $display("FAIL fetch_resp_cycle: gnt/rvalid/halt=%b want 001", {f_gnt, f_rvalid, mem_halt});
        end
        tick();
        n_checks++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL fetch_rvalid: rvalid=%b rdata=%h want 1 deadbeef", f_rvalid, f_rdata);
        end
        tick();
        n_checks++;
        if ({f_rvalid, f_rdata} !== {1'b0, 32'hDEADBEEF}) begin
            n_fail++;
            $display("FAIL fetch_hold: rvalid=%b rdata=%h want 0 deadbeef", f_rvalid, f_rdata);
        end
    endtask

    task automatic test_pair_wrap;
        d_req = 1'b1; d_we = 1'b1; d_pair = 1'b1; d_addr = 11'h7FF;
        d_wdata0 = 32'h11111111; d_wdata1 = 32'h22222222;
        tick();
        n_checks++;
        if ({d_gnt, mem_halt, mem_web1, mem_web2, mem_addr1, mem_addr2} !== {4'b1000, 11'h7FF, 11'h000}) begin
            n_fail++;
            $display("FAIL pair_pins: gnt=%b halt=%b web=%b%b addr1=%h addr2=%h want 1 0 00 7ff 000",
                     d_gnt, mem_halt, mem_web1, mem_web2, mem_addr1, mem_addr2);
        end
        n_checks++;
        if ({mem_wdata1, mem_wdata2} !== {32'h11111111, 32'h22222222}) begin
            n_fail++;
            $display("FAIL pair_wdata: wd1=%h wd2=%h want 11111111 22222222", mem_wdata1, mem_wdata2);
        end
        clear_inputs();
        tick();
        n_checks++;
        if ({d_gnt, mem_halt, mem_web1, mem_web2, d_rvalid, mem_addr2} !== {5'b01110, 11'h000}) begin
            n_fail++;
            $display("FAIL pair_after: gnt/halt/web1/web2/rvalid=%b addr2=%h want 01110 000",
                     {d_gnt, mem_halt, mem_web1, mem_web2, d_rvalid}, mem_addr2);
        end
        n_checks++;
        if ({mem[11'h7FF], mem[11'h000]} !== {32'h11111111, 32'h22222222}) begin
            n_fail++;
            $display("FAIL pair_mem: mem[7ff]=%h mem[0]=%h want 11111111 22222222", mem[11'h7FF], mem[11'h000]);
        end
    endtask

    task automatic test_read_pair_ignored;
        mem[11'h005] = 32'h5A5A0005;
        d_req = 1'b1; d_we = 1'b0; d_pair = 1'b1; d_addr = 11'h005; d_wdata1 = 32'hBAD0BAD0;
        tick();
        n_checks++;
        if ({d_gnt, mem_halt, mem_web1, mem_web2, mem_addr1, mem_addr2} !== {4'b1011, 11'h005, 11'h000}) begin
            n_fail++;
            $display("FAIL rdpair_pins: gnt=%b halt=%b web=%b%b addr1=%h addr2=%h want 1 0 11 005 000",
                     d_gnt, mem_halt, mem_web1, mem_web2, mem_addr1, mem_addr2);
        end
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'h5A5A0005}) begin
            n_fail++;
            $display("FAIL rdpair_rvalid: rvalid=%b rdata=%h want 1 5a5a0005", d_rvalid, d_rdata);
        end
    endtask

    task automatic test_streak;
        int got [6];
        int exp_seq [6] = '{1, 1, 1, 1, 0, 1};
        int n_g = 0;
        do_reset();
        f_req = 1'b1; f_addr = 11'h020;
        d_req = 1'b1; d_we = 1'b0; d_addr = 11'h030;
        for (int c = 0; c < 60 && n_g < 6; c++) begin
            tick();
            if (f_gnt || d_gnt) begin
                got[n_g] = (f_gnt && d_gnt) ? 2 : (d_gnt ? 1 : 0);
                n_g++;
            end
        end
        n_checks++;
        if (n_g != 6) begin
            n_fail++;
            $display("FAIL streak_count: got %0d grants want 6 within budget", n_g);
        end
        for (int i = 0; i < n_g; i++) begin
            n_checks++;
            if (got[i] != exp_seq[i]) begin
                n_fail++;
                $display("FAIL streak_order[%0d]: got %0d want %0d (1=debug 0=fetch 2=both)", i, got[i], exp_seq[i]);
            end
        end
        clear_inputs();
        repeat (4) tick();
    endtask

    task automatic test_cpu_halt;
        bit bad = 1'b0;
        do_reset();
        mem[11'h040] = 32'hC0DE0040;
        cpu_halt = 1'b1; f_req = 1'b1; f_addr = 11'h040;
        repeat (6) begin
            tick();
            if (f_gnt || !mem_halt) bad = 1'b1;
        end
        n_checks++;
        if (bad) begin
            n_fail++;
            $display("FAIL halt_block: got fetch activity while halted want none");
        end
        cpu_halt = 1'b0;
        tick();
        n_checks++;
        if ({f_gnt, mem_halt, mem_addr1} !== {2'b10, 11'h040}) begin
            n_fail++;
            $display("FAIL halt_release: gnt=%b halt=%b addr1=%h want 1 0 040", f_gnt, mem_halt, mem_addr1);
        end
        cpu_halt = 1'b1; f_req = 1'b0;
        tick();
        tick();
        n_checks++;
        if ({f_rvalid, f_rdata} !== {1'b1, 32'hC0DE0040}) begin
            n_fail++;
            $display("FAIL halt_no_abort: rvalid=%b rdata=%h want 1 c0de0040", f_rvalid, f_rdata);
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid;
        do_reset();
        mem[11'h060] = 32'hAAAA0060;
        mem[11'h061] = 32'hBBBB0061;
        d_req = 1'b1; d_addr = 11'h060;
        tick();
        clear_inputs();
        tick();
        tick();
        n_checks++;
        if ({d_rvalid, d_rdata} !== {1'b1, 32'hAAAA0060}) begin
            n_fail++;
            $display("FAIL mid_first_read: rvalid=%b rdata=%h want 1 aaaa0060", d_rvalid, d_rdata);
        end
        tick();
        d_req = 1'b1; d_addr = 11'h061;
        tick();
        clear_inputs();
        tick();
        #2 Reset_n = 1'b0;
        #1;
        n_checks++;
        if ({f_gnt, d_gnt, f_rvalid, d_rvalid, mem_halt, mem_web1, mem_web2} !== 7'b0000111 ||
            {d_rdata, f_rdata, mem_addr1, mem_addr2, mem_wdata1, mem_wdata2} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_now: ctrl=%b drd=%h addr1=%h want 0000111 0 0",
                     {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_halt, mem_web1, mem_web2}, d_rdata, mem_addr1);
        end
        tick();
        n_checks++;
        if ({d_rvalid, d_rdata, mem_halt} !== {1'b0, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL mid_reset_dropped: rvalid=%b rdata=%h halt=%b want 0 0 1", d_rvalid, d_rdata, mem_halt);
        end
        Reset_n = 1'b1;
    endtask

    task automatic test_random;
        int busy = 0, streak = 0, rd_cnt = 0;
        bit rd_fetch = 1'b0, elig;
        logic [DW-1:0] rd_data = '0, e_frdata = '0, e_drdata = '0, e_wd1 = '0, e_wd2 = '0;
        logic [AW-1:0] e_a1 = '0, e_a2 = '0;
        logic e_fg, e_dg, e_fv, e_dv, e_halt, e_w1, e_w2;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (!f_req) begin
                if ($urandom_range(0, 2) == 0) begin f_req = 1'b1; f_addr = AW'($urandom); end
            end else if ($urandom_range(0, 15) == 0) begin
                f_req = 1'b0;
            end
            if (!d_req) begin
                if ($urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom); d_pair = 1'($urandom);
                    d_addr = ($urandom_range(0, 5) == 0) ? 11'h7FF : AW'($urandom);
                    d_wdata0 = $urandom; d_wdata1 = $urandom;
                end
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 1'b0;
            end
            if ($urandom_range(0, 9) == 0) cpu_halt = ~cpu_halt;

            e_fg = 0; e_dg = 0; e_fv = 0; e_dv = 0; e_halt = 1; e_w1 = 1; e_w2 = 1;
            if (rd_cnt > 0) begin
                rd_cnt--;
                if (rd_cnt == 0) begin
                    if (rd_fetch) begin e_fv = 1; e_frdata = rd_data; end
                    else begin e_dv = 1; e_drdata = rd_data; end
                end
            end
            if (busy > 0) begin
                busy--;
            end else begin
                elig = f_req && !cpu_halt;
                if (d_req && !(elig && streak == 4)) begin
                    e_dg = 1; e_halt = 0; e_a1 = d_addr;
                    if (d_we) begin
                        e_w1 = 0; e_wd1 = d_wdata0; busy = 1;
                        if (d_pair) begin e_w2 = 0; e_a2 = AW'(d_addr + 1); e_wd2 = d_wdata1; end
                    end else begin
                        busy = 2; rd_cnt = 2; rd_fetch = 0; rd_data = mem[d_addr];
                    end
                    streak = elig ? ((streak < 4) ? streak + 1 : 4) : 0;
                end else if (elig) begin
                    e_fg = 1; e_halt = 0; e_a1 = f_addr;
                    busy = 2; rd_cnt = 2; rd_fetch = 1; rd_data = mem[f_addr];
                    streak = 0;
                end else begin
                    streak = 0;
                end
            end

            tick();
            n_checks++;
            if ({f_gnt, d_gnt, f_rvalid, d_rvalid, mem_halt, mem_web1, mem_web2} !== {e_fg, e_dg, e_fv, e_dv, e_halt, e_w1, e_w2}) begin
                n_fail++;
                $display("FAIL rnd_ctrl cyc %0d: got %b want %b", cyc,
                         {f_gnt, d_gnt, f_rvalid, d_rvalid, mem_halt, mem_web1, mem_web2}, {e_fg, e_dg, e_fv, e_dv, e_halt, e_w1, e_w2});
            end
            n_checks++;
            if ({f_rdata, d_rdata, mem_addr2} !== {e_frdata, e_drdata, e_a2}) begin
                n_fail++;
                $display("FAIL rnd_data cyc %0d: frd=%h drd=%h addr2=%h want %h %h %h", cyc,
                         f_rdata, d_rdata, mem_addr2, e_frdata, e_drdata, e_a2);
            end
            if (!e_halt) begin
                n_checks++;
                if (mem_addr1 !== e_a1) begin
                    n_fail++;
                    $display("FAIL rnd_addr1 cyc %0d: got %h want %h", cyc, mem_addr1, e_a1);
                end
            end
            if (!e_w1) begin
                n_checks++;
                if (mem_wdata1 !== e_wd1 || (!e_w2 && mem_wdata2 !== e_wd2)) begin
                    n_fail++;
                    $display("FAIL rnd_wdata cyc %0d: wd1=%h wd2=%h want %h %h", cyc, mem_wdata1, mem_wdata2, e_wd1, e_wd2);
                end
            end
            if (e_fg) f_req = 1'b0;
            if (e_dg) d_req = 1'b0;
        end
        clear_inputs();
        repeat (4) tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2048; i++) mem[i] = $urandom;
        test_reset();
        test_fetch_read();
        test_pair_wrap();
        test_read_pair_ignored();
        test_streak();
        test_cpu_halt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
